ctrl_seq_cnt: RTL and testbench
===============================

Name: ctrl_seq_cnt

Overview:
- Sequencing counter bank, directly downstream of and feeding back to the controller FSM.
- Decodes the FSM state (ctrl::fsmState_e) and maintains three counters:
  - tap counter inside a convolution;
  - stage counter across upsampler stages;
  - vector counter across polyphase vectors.
- Returns the vector_pass / last_stage / last_vector flags to the FSM.
- Drives the address and strobe signals used by the datapath (coefficient/sample address, accumulator clear/enable, output valid, input request).

Parameters:
- NUM_STAGES, 4, number of upsampler stages (≥1)
- NUM_VECTORS, 8, number of polyphase vectors per input sample (≥1)
- MAX_TAPS, 64, maximum taps per vector; tap counter width TAP_W = $clog2(MAX_TAPS)
- STG_W, $clog2(NUM_STAGES) min 1, stage index width
- VEC_W, $clog2(NUM_VECTORS) min 1, vector index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- en  in  1  clock enable, shared with the FSM
- state  in  3  ctrl::fsmState_e current FSM state (S1..S8 = 0..7)
- taps_len  in  TAP_W+1  taps in the current vector; 0 is treated as 1; values >MAX_TAPS are clamped to MAX_TAPS
- vector_pass  out  1  final tap of the convolution is being processed
- last_stage  out  1  stage_idx == NUM_STAGES-1
- last_vector  out  1  vector_idx == NUM_VECTORS-1
- tap_idx  out  TAP_W  current tap index
- stage_idx  out  STG_W  current stage
- vector_idx  out  VEC_W  current vector
- coef_addr  out  STG_W+VEC_W+TAP_W  {stage_idx, vector_idx, tap_idx}
- acc_clr  out  1  accumulator clear strobe
- acc_en  out  1  accumulator enable
- out_valid  out  1  output sample strobe
- in_req  out  1  new input sample request

Behaviour:
Reset and enable:
- Reset (rst==0 at a clk edge) takes priority over en.
- Reset zeroes all counters and all registered strobes. Outputs are 0 on the cycle after reset; last_stage and last_vector reflect index 0.
- Reset mid-convolution discards the partial count; no strobe is emitted.
- en==0: all counters hold. acc_en, acc_clr, out_valid and in_req are forced to 0 (combinational gating). Flags keep their decoded value.

Strobes and flags (combinational from state and en):
- acc_clr = en & (state==S2)
- acc_en = en & (state==S3)
- out_valid = en & (state==S6)
- in_req = en & (state==S7)
- vector_pass = (state==S3) & (tap_idx == eff_len-1), where eff_len is the clamped taps_len.
- last_stage and last_vector are pure index compares, valid in every state. The FSM samples them in S5 and S6 respectively.

Counter updates (per en cycle):
- S2: tap_idx <= 0.
- S3: if vector_pass, tap_idx holds at eff_len-1; else tap_idx <= tap_idx+1.
  - The FSM stays in S3 for exactly eff_len enabled cycles. eff_len==1 gives vector_pass on the first S3 cycle.
- S8:
  - If !last_stage: stage_idx <= stage_idx+1.
  - Else: stage_idx <= 0, and vector_idx <= last_vector ? 0 : vector_idx+1.
  - tap_idx <= 0.
- S1, S4, S5, S6, S7: counters hold.

Other rules:
- taps_len is sampled only in S3. A change during S3 takes effect on the next compare.
- If taps_len shrinks below tap_idx+1 during S3, vector_pass asserts immediately and tap_idx holds.
- Latency: flags are combinational. Index changes are visible the cycle after the S8 enabled edge.
- Wrap: after NUM_STAGES*NUM_VECTORS S8 visits, all indices return to 0.

Optional Feature:
- Macro CTRL_SEQ_CNT_WDOG_EN.
- When defined:
  - Adds output err (1 bit), sticky, cleared only by reset.
  - A watchdog counter (TAP_W+1 bits) counts enabled cycles spent in S3. It clears on any non-S3 enabled cycle.
  - err sets when the count exceeds MAX_TAPS, i.e. the FSM is stuck in S3.
  - err also sets if state decodes outside S1..S8.
- When undefined: no err port, no watchdog logic.

Decomposition:
- Package ctrl:
  - fsmState_e (3-bit, S1=0..S8=7), shared with the FSM.
  - Localparam defaults for NUM_STAGES, NUM_VECTORS, MAX_TAPS.
  - Function for the coef_addr concatenation width.
- Sub-module ctrl_wrap_cnt: generic enable/clear/increment counter with terminal-count flag and wrap to 0. Instantiated twice, for stage and vector. The tap counter stays inline because of its saturate-at-eff_len behaviour.

Test Plan:
- Reset: drive rst=0 for 2 cycles mid-S3 with tap_idx=5 → next cycle all indices 0, strobes 0, last_stage=(NUM_STAGES==1).
- Convolution: taps_len=4, state S2 then S3 for 4 cycles → tap_idx 0,1,2,3; vector_pass only on the 4th S3 cycle; acc_en high 4 cycles; acc_clr 1 cycle in S2.
- Edge taps: taps_len=0 → vector_pass on the first S3 cycle. taps_len=100 with MAX_TAPS=64 → vector_pass at tap_idx=63.
- Full sweep: NUM_STAGES=4, NUM_VECTORS=8 loop over 32 S8 visits → stage_idx cycles 0..3; vector_idx increments on stage wrap; after visit 32 all indices 0; in_req pulses once per 8 vectors.
- Enable hold: en=0 for 3 cycles in S3 at tap_idx=2 → tap_idx stays 2, acc_en=0; resumes counting at 3.
- With CTRL_SEQ_CNT_WDOG_EN: hold S3 with vector_pass ignored for MAX_TAPS+1 enabled cycles → err=1, stays 1 until rst=0.

Source files
------------

// File: rtl/ctrl_seq_cnt_pkg.sv
// Shared controller types: FSM state encoding, default sizing and width helpers.
package ctrl;

  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5,
    S7 = 3'd6,
    S8 = 3'd7
  } fsmState_e;

  localparam int NUM_STAGES_DEF  = 4;
  localparam int NUM_VECTORS_DEF = 8;
  localparam int MAX_TAPS_DEF    = 64;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int coef_addr_w(input int stg_w, input int vec_w, input int tap_w);
    return stg_w + vec_w + tap_w;
  endfunction

endpackage

// File: rtl/ctrl_seq_cnt_if.sv
// FSM <-> sequencing counter bank bundle. The err signal exists only with CTRL_SEQ_CNT_WDOG_EN.
interface ctrl_seq_cnt_if #(
  parameter int NUM_STAGES  = ctrl::NUM_STAGES_DEF,
  parameter int NUM_VECTORS = ctrl::NUM_VECTORS_DEF,
  parameter int MAX_TAPS    = ctrl::MAX_TAPS_DEF
);
  localparam int TAP_W  = $clog2(MAX_TAPS);
  localparam int STG_W  = ctrl::idx_w(NUM_STAGES);
  localparam int VEC_W  = ctrl::idx_w(NUM_VECTORS);
  localparam int ADDR_W = ctrl::coef_addr_w(STG_W, VEC_W, TAP_W);

  logic              en;
  ctrl::fsmState_e   state;
  logic [TAP_W:0]    taps_len;
  logic              vector_pass;
  logic              last_stage;
  logic              last_vector;
  logic [TAP_W-1:0]  tap_idx;
  logic [STG_W-1:0]  stage_idx;
  logic [VEC_W-1:0]  vector_idx;
  logic [ADDR_W-1:0] coef_addr;
  logic              acc_clr;
  logic              acc_en;
  logic              out_valid;
  logic              in_req;
`ifdef CTRL_SEQ_CNT_WDOG_EN
  logic              err;
`endif

  modport master (
    output en, state, taps_len,
    input  vector_pass, last_stage, last_vector, tap_idx, stage_idx, vector_idx,
    input  coef_addr, acc_clr, acc_en, out_valid, in_req
`ifdef CTRL_SEQ_CNT_WDOG_EN
    , input err
`endif
  );

  modport slave (
    input  en, state, taps_len,
    output vector_pass, last_stage, last_vector, tap_idx, stage_idx, vector_idx,
    output coef_addr, acc_clr, acc_en, out_valid, in_req
`ifdef CTRL_SEQ_CNT_WDOG_EN
    , output err
`endif
  );

endinterface

// File: rtl/ctrl_seq_cnt_wrap_cnt.sv
// Generic wrapping counter: clear beats increment, terminal count at N-1 wraps to 0.
module ctrl_wrap_cnt #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/ctrl_seq_cnt.sv
// Sequencing counter bank: decodes FSM state into tap/stage/vector counters, flags and datapath strobes.
// Optional watchdog and err output are built when CTRL_SEQ_CNT_WDOG_EN is defined.
module ctrl_seq_cnt
  import ctrl::*;
#(
  parameter int NUM_STAGES  = NUM_STAGES_DEF,
  parameter int NUM_VECTORS = NUM_VECTORS_DEF,
  parameter int MAX_TAPS    = MAX_TAPS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  ctrl_seq_cnt_if.slave bus
);

  localparam int TAP_W = $clog2(MAX_TAPS);
  localparam int STG_W = idx_w(NUM_STAGES);
  localparam int VEC_W = idx_w(NUM_VECTORS);
  localparam logic [TAP_W:0] MAX_TAPS_L = (TAP_W + 1)'(MAX_TAPS);

  fsmState_e        st;
  logic [TAP_W:0]   eff_len;
  logic [TAP_W:0]   tap_p1;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             vector_pass;
  logic [STG_W-1:0] stage_idx;
  logic [VEC_W-1:0] vector_idx;
  logic             last_stage;
  logic             last_vector;
  logic             stg_inc;
  logic             vec_inc;

  assign st = bus.state;

  // Zero-length vectors still take one tap; oversize lengths clamp to the tap memory depth.
  always_comb begin
    eff_len = bus.taps_len;
    if (bus.taps_len == '0) begin
      eff_len = (TAP_W + 1)'(1);
    end else if (bus.taps_len > MAX_TAPS_L) begin
      eff_len = MAX_TAPS_L;
    end
  end

  // ">=" rather than "==" so a length shrinking under the current index ends the pass at once.
  assign tap_p1      = {1'b0, tap_q} + (TAP_W + 1)'(1);
  assign vector_pass = (st == S3) && (tap_p1 >= eff_len);

  always_comb begin
    tap_d = tap_q;
    if (bus.en) begin
      unique case (st)
        S2:      tap_d = '0;
        S3:      if (!vector_pass) tap_d = tap_q + TAP_W'(1);
        S8:      tap_d = '0;
        default: tap_d = tap_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tap_q <= '0;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign stg_inc = bus.en && (st == S8);
  assign vec_inc = stg_inc && last_stage;

  ctrl_wrap_cnt #(
    .N (NUM_STAGES),
    .W (STG_W)
  ) u_stage_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (stg_inc),
    .cnt_o (stage_idx),
    .tc_o  (last_stage)
  );

  ctrl_wrap_cnt #(
    .N (NUM_VECTORS),
    .W (VEC_W)
  ) u_vector_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (vec_inc),
    .cnt_o (vector_idx),
    .tc_o  (last_vector)
  );

  assign bus.vector_pass = vector_pass;
  assign bus.last_stage  = last_stage;
  assign bus.last_vector = last_vector;
  assign bus.tap_idx     = tap_q;
  assign bus.stage_idx   = stage_idx;
  assign bus.vector_idx  = vector_idx;
  assign bus.coef_addr   = {stage_idx, vector_idx, tap_q};
  assign bus.acc_clr     = bus.en && (st == S2);
  assign bus.acc_en      = bus.en && (st == S3);
  assign bus.out_valid   = bus.en && (st == S6);
  assign bus.in_req      = bus.en && (st == S7);

`ifdef CTRL_SEQ_CNT_WDOG_EN
  logic [TAP_W:0] wdog_q, wdog_d;
  logic           err_q, err_d;
  logic           illegal_state;

  assign illegal_state = !(bus.state inside {S1, S2, S3, S4, S5, S6, S7, S8});

  // Counter saturates one past MAX_TAPS so a long stall cannot wrap it back to zero.
  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (bus.en) begin
      if (st == S3) begin
        if (wdog_q <= MAX_TAPS_L) wdog_d = wdog_q + (TAP_W + 1)'(1);
        if (wdog_q >= MAX_TAPS_L) err_d = 1'b1;
      end else begin
        wdog_d = '0;
      end
    end
    if (illegal_state) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_ctrl_seq_cnt.sv
// Scoreboard bench for ctrl_seq_cnt: a behavioural model queues expected outputs per cycle.
module tb_ctrl_seq_cnt;
  import ctrl::*;

  localparam int NS = 4;
  localparam int NV = 8;
  localparam int MT = 64;

  typedef struct packed {
    logic        vp;
    logic        ls;
    logic        lv;
    logic [5:0]  tap;
    logic [1:0]  stg;
    logic [2:0]  vec;
    logic [10:0] addr;
    logic        clr;
    logic        aen;
    logic        ov;
    logic        ireq;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_tap = 0, m_stg = 0, m_vec = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];
  obs_t last_obs;

  always #5 clk = ~clk;

  ctrl_seq_cnt_if #(.NUM_STAGES(NS), .NUM_VECTORS(NV), .MAX_TAPS(MT)) bus ();

  ctrl_seq_cnt #(.NUM_STAGES(NS), .NUM_VECTORS(NV), .MAX_TAPS(MT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One cycle: apply inputs, queue model prediction, capture DUT at negedge, advance model at posedge.
  task automatic drive(input logic r, input logic e, input fsmState_e s, input int taps);
    obs_t x, o;
    int   el;
    rst          = r;
    bus.en       = e;
    bus.state    = s;
    bus.taps_len = 7'(taps);
    el = (taps == 0) ? 1 : ((taps > MT) ? MT : taps);
    x.vp   = (s == S3) && (m_tap + 1 >= el);
    x.ls   = (m_stg == NS - 1);
    x.lv   = (m_vec == NV - 1);
    x.tap  = 6'(m_tap);
    x.stg  = 2'(m_stg);
    x.vec  = 3'(m_vec);
    x.addr = {2'(m_stg), 3'(m_vec), 6'(m_tap)};
    x.clr  = e && (s == S2);
    x.aen  = e && (s == S3);
    x.ov   = e && (s == S6);
    x.ireq = e && (s == S7);
    exp_q.push_back(x);
    @(negedge clk);
    o.vp = bus.vector_pass; o.ls = bus.last_stage; o.lv = bus.last_vector;
    o.tap = bus.tap_idx; o.stg = bus.stage_idx; o.vec = bus.vector_idx;
    o.addr = bus.coef_addr; o.clr = bus.acc_clr; o.aen = bus.acc_en;
    o.ov = bus.out_valid; o.ireq = bus.in_req;
    obs_q.push_back(o);
    last_obs = o;
    @(posedge clk);
    if (!r) begin
      m_tap = 0; m_stg = 0; m_vec = 0;
    end else if (e) begin
      case (s)
        S2: m_tap = 0;
        S3: if (!x.vp) m_tap++;
        S8: begin
          m_tap = 0;
          if (m_stg == NS - 1) begin
            m_stg = 0;
            m_vec = (m_vec == NV - 1) ? 0 : m_vec + 1;
          end else begin
            m_stg++;
          end
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    drive(1'b0, 1'b0, S1, 4);
    drive(1'b0, 1'b0, S1, 4);
    drive(1'b1, 1'b1, S2, 8);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, S3, 8);
    checks++;
    if (bus.tap_idx !== 6'd5) begin
      errors++; $display("FAIL reset_pre tap: got %0d expected 5", bus.tap_idx);
    end
    drive(1'b0, 1'b1, S3, 8);
    drive(1'b0, 1'b1, S3, 8);
    drive(1'b1, 1'b1, S1, 8);
    checks++;
    if (last_obs !== obs_t'({1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 3'd0, 11'd0, 4'd0})) begin
      errors++; $display("FAIL reset_state: got %h expected 0", last_obs);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_step: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_conv();
    obs_t e, o;
    int   n_aen = 0, n_clr = 0, n_vp = 0;
    drive(1'b1, 1'b1, S2, 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, S3, 4);
      checks++;
      if (last_obs.tap !== 6'(i) || last_obs.vp !== (i == 3)) begin
        errors++; $display("FAIL conv_tap%0d: got tap %0d vp %b expected tap %0d vp %b",
                           i, last_obs.tap, last_obs.vp, i, (i == 3));
      end
    end
    drive(1'b1, 1'b1, S4, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      n_aen += int'(o.aen); n_clr += int'(o.clr); n_vp += int'(o.vp);
      if (o !== e) begin errors++; $display("FAIL conv_step: got %h expected %h", o, e); end
    end
    checks++;
    if (n_aen != 4 || n_clr != 1 || n_vp != 1) begin
      errors++; $display("FAIL conv_counts: got aen %0d clr %0d vp %0d expected 4 1 1", n_aen, n_clr, n_vp);
    end
  endtask

  task automatic test_edge_taps();
    obs_t e, o;
    int   n_vp = 0;
    drive(1'b1, 1'b1, S2, 0);
    drive(1'b1, 1'b1, S3, 0);
    checks++;
    if (last_obs.vp !== 1'b1 || last_obs.tap !== 6'd0) begin
      errors++; $display("FAIL taps_zero: got vp %b tap %0d expected vp 1 tap 0", last_obs.vp, last_obs.tap);
    end
    drive(1'b1, 1'b1, S2, 100);
    for (int i = 0; i < MT; i++) begin
      drive(1'b1, 1'b1, S3, 100);
      n_vp += int'(last_obs.vp);
    end
    checks++;
    if (last_obs.vp !== 1'b1 || last_obs.tap !== 6'd63 || n_vp != 1) begin
      errors++; $display("FAIL taps_clamp: got vp %b tap %0d count %0d expected vp 1 tap 63 count 1",
                         last_obs.vp, last_obs.tap, n_vp);
    end
    drive(1'b1, 1'b1, S1, 100);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL edge_step: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_sweep();
    obs_t e, o;
    int   n_req = 0;
    for (int v = 0; v < NS * NV; v++) begin
      drive(1'b1, 1'b1, S6, 4);
      if (m_stg == NS - 1 && m_vec == NV - 1) drive(1'b1, 1'b1, S7, 4);
      drive(1'b1, 1'b1, S8, 4);
    end
    drive(1'b1, 1'b1, S1, 4);
    checks++;
    if (last_obs.stg !== 2'd0 || last_obs.vec !== 3'd0 || last_obs.tap !== 6'd0) begin
      errors++; $display("FAIL sweep_wrap: got stg %0d vec %0d tap %0d expected 0 0 0",
                         last_obs.stg, last_obs.vec, last_obs.tap);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      n_req += int'(o.ireq);
      if (o !== e) begin errors++; $display("FAIL sweep_step: got %h expected %h", o, e); end
    end
    checks++;
    if (n_req != 1) begin
      errors++; $display("FAIL sweep_in_req: got %0d pulses expected 1", n_req);
    end
  endtask

  task automatic test_enable_hold();
    obs_t e, o;
    drive(1'b1, 1'b1, S2, 8);
    drive(1'b1, 1'b1, S3, 8);
    drive(1'b1, 1'b1, S3, 8);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, S3, 8);
      checks++;
      if (last_obs.tap !== 6'd2 || last_obs.aen !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: got tap %0d aen %b expected tap 2 aen 0", i, last_obs.tap, last_obs.aen);
      end
    end
    drive(1'b1, 1'b1, S3, 8);
    drive(1'b1, 1'b1, S3, 8);
    checks++;
    if (last_obs.tap !== 6'd3) begin
      errors++; $display("FAIL hold_resume: got tap %0d expected 3", last_obs.tap);
    end
    drive(1'b1, 1'b1, S1, 8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL hold_step: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    drive(1'b1, 1'b1, S2, 8);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, S3, 8);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, S3, 3);
      checks++;
      if (last_obs.vp !== 1'b1 || last_obs.tap !== 6'd5) begin
        errors++; $display("FAIL shrink_%0d: got vp %b tap %0d expected vp 1 tap 5", i, last_obs.vp, last_obs.tap);
      end
    end
    drive(1'b1, 1'b1, S2, 3);
    drive(1'b1, 1'b1, S3, 3);
    drive(1'b1, 1'b1, S1, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_step: got %h expected %h", o, e); end
    end
  endtask

`ifdef CTRL_SEQ_CNT_WDOG_EN
  task automatic test_wdog();
    drive(1'b1, 1'b1, S2, 4);
    for (int i = 0; i < MT; i++) drive(1'b1, 1'b1, S3, 4);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL wdog_early: got %b expected 0", bus.err); end
    drive(1'b1, 1'b1, S3, 4);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL wdog_set: got %b expected 1", bus.err); end
    drive(1'b1, 1'b1, S1, 4);
    drive(1'b1, 1'b1, S2, 4);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b expected 1", bus.err); end
    drive(1'b0, 1'b1, S1, 4);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %b expected 0", bus.err); end
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  initial begin
    bus.en       = 1'b0;
    bus.state    = S1;
    bus.taps_len = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_conv();
    test_edge_taps();
    test_sweep();
    test_enable_hold();
    test_back_to_back();
`ifdef CTRL_SEQ_CNT_WDOG_EN
    test_wdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
